// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer: state encoding, default frame
// geometry and a width helper used by the sequencer and its counter.
package frame_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int DEF_IMG_W  = 512;
   localparam int DEF_IMG_H  = 512;
   localparam int DEF_ADDR_W = 11;

   // Counter width for values 0..n-1; never narrower than one bit.
   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_cnt.sv
// Column/row advance counter: column wraps at IMG_W-1 and bumps the row,
// row wraps after ROWS rows. Synchronous clear has priority over advance.
module frame_cnt
   import frame_seq_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int ROWS  = DEF_IMG_H,
   parameter int COL_W = bits_for(IMG_W),
   parameter int ROW_W = bits_for(ROWS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             row_step_o
);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             col_end;
   logic             row_end;

   assign col_end    = (col_q == COL_W'(IMG_W - 1));
   assign row_end    = (row_q == ROW_W'(ROWS - 1));
   assign row_step_o = en_i & col_end;
   assign col_o      = col_q;
   assign row_o      = row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/frame_seq.sv
// Frame sequencer: fills PIPE_ROWS rows of line buffer, streams the frame with
// pass-through handshakes, then flushes the pipeline with the input stalled.
module frame_seq
   import frame_seq_pkg::*;
#(
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IMG_H     = DEF_IMG_H,
   parameter int PIPE_ROWS = 2,
   parameter int LB_NUM    = 4,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic              out_last,
   output logic              en,
   output logic [ADDR_W-1:0] lb_waddr,
   output logic [1:0]        lb_wsel,
   output logic              edg,
   output logic [2:0]        state,
   output logic              done,
   output logic              err
);

   localparam int ROWS  = IMG_H + PIPE_ROWS;
   localparam int COL_W = bits_for(IMG_W);
   localparam int ROW_W = bits_for(ROWS);

   state_e           state_q, state_d;
   logic [1:0]       lb_wsel_q, lb_wsel_d;
   logic             err_q, err_d;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             row_step;
   logic             clr_c, en_c, in_ready_c, out_valid_c;
   logic             col_last, fill_last, in_final, flush_last, accept;

   frame_cnt #(
      .IMG_W (IMG_W),
      .ROWS  (ROWS),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr_c),
      .en_i       (en_c),
      .col_o      (col),
      .row_o      (row),
      .row_step_o (row_step)
   );

   // The advance row equals the input row until the input side is exhausted.
   assign col_last   = (col == COL_W'(IMG_W - 1));
   assign fill_last  = (PIPE_ROWS > 0) && (row == ROW_W'(PIPE_ROWS - 1)) && col_last;
   assign in_final   = (row == ROW_W'(IMG_H - 1)) && col_last;
   assign flush_last = (row == ROW_W'(ROWS - 1)) && col_last;

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      en_c        = 1'b0;
      clr_c       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            en_c       = in_valid;
            if (in_valid)
               state_d = (PIPE_ROWS == 0 || fill_last) ? ST_RUN : ST_FILL;
         end
         ST_FILL: begin
            in_ready_c = 1'b1;
            en_c       = in_valid;
            if (in_valid && fill_last)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            in_ready_c  = out_ready;
            out_valid_c = in_valid;
            en_c        = in_valid & out_ready;
            if (en_c && in_final)
               state_d = (PIPE_ROWS == 0) ? ST_DONE : ST_FLUSH;
         end
         ST_FLUSH: begin
            out_valid_c = 1'b1;
            en_c        = out_ready;
            if (en_c && flush_last)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            clr_c   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            clr_c   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Framing is tracked by the counter; in_last only feeds the error flag.
   assign accept = in_valid & in_ready_c;
   assign err_d  = err_q | (accept & (in_last ^ in_final));

   always_comb begin
      lb_wsel_d = lb_wsel_q;
      if (clr_c)
         lb_wsel_d = '0;
      else if (row_step)
         lb_wsel_d = (lb_wsel_q == 2'(LB_NUM - 1)) ? 2'd0 : lb_wsel_q + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         lb_wsel_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lb_wsel_q <= lb_wsel_d;
         err_q     <= err_d;
      end
   end

   // en is gated so an in_valid held high during reset cannot look like an advance.
   assign en        = en_c & rst_n;
   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_c;
   assign out_last  = out_valid_c & flush_last;
   assign edg       = out_valid_c & ((row == ROW_W'(PIPE_ROWS)) || (row == ROW_W'(ROWS - 1)) ||
                                     (col == '0) || col_last);
   assign lb_waddr  = ADDR_W'(col);
   assign lb_wsel   = lb_wsel_q;
   assign state     = state_q;
   assign done      = (state_q == ST_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_frame_seq.sv
// Self-checking bench for frame_seq on a 4x3 frame with one row of latency;
// a count-based frame model predicts every output each cycle.
module tb_frame_seq;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int P     = 1;
   localparam int LB    = 4;
   localparam int AW    = 11;
   localparam int NPIX  = W * H;
   localparam int FILLP = P * W;
   localparam int TOTAL = (H + P) * W;
   localparam logic [22:0] RESET_V = 23'h080000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, out_last, en, edg, done, err;
   logic [AW-1:0] lb_waddr;
   logic [1:0]    lb_wsel;
   logic [2:0]    state;

   int n_checks = 0;
   int n_fail   = 0;
   int m_in     = 0;
   int m_adv    = 0;
   bit m_err    = 1'b0;
   logic [22:0] exp_v;
   logic [22:0] obs_v;

   always #5 clk = ~clk;

   frame_seq #(
      .IMG_W     (W),
      .IMG_H     (H),
      .PIPE_ROWS (P),
      .LB_NUM    (LB),
      .ADDR_W    (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .en        (en),
      .lb_waddr  (lb_waddr),
      .lb_wsel   (lb_wsel),
      .edg       (edg),
      .state     (state),
      .done      (done),
      .err       (err)
   );

   assign obs_v = {state, in_ready, out_valid, out_last, en, edg, done, err, lb_wsel, lb_waddr};

   // Expected outputs from accepted-pixel and advance counts alone.
   function automatic logic [22:0] model_vec(input bit iv, input bit ordy);
      int st, col, row, orow;
      bit ir, ov, e, eg, ol;
      if (m_adv == TOTAL)     st = 4;
      else if (m_adv == 0)    st = 0;
      else if (m_in < FILLP)  st = 1;
      else if (m_in < NPIX)   st = 2;
      else                    st = 3;
      ir = (st <= 1) || (st == 2 && ordy);
      ov = (st == 2 && iv) || (st == 3);
      e  = ((st <= 1) && iv) || (st == 2 && iv && ordy) || (st == 3 && ordy);
      col  = m_adv % W;
      row  = m_adv / W;
      orow = row - P;
      eg = ov && (orow == 0 || orow == H - 1 || col == 0 || col == W - 1);
      ol = ov && orow == H - 1 && col == W - 1;
      return {3'(st), ir, ov, ol, e, eg, (st == 4), m_err, 2'(row % LB), 11'(col)};
   endfunction

   task automatic model_clear();
      m_in = 0; m_adv = 0; m_err = 1'b0;
   endtask

   task automatic drive(input bit iv, input bit il, input bit ordy);
      in_valid = iv; in_last = il; out_ready = ordy;
      @(negedge clk);
      exp_v = model_vec(iv, ordy);
   endtask

   task automatic advance(input bit iv, input bit il);
      @(posedge clk);
      if (exp_v[22:20] == 3'd4) begin
         m_in = 0; m_adv = 0;
      end else begin
         if (iv && exp_v[19]) begin
            if (il != (m_in == NPIX - 1)) m_err = 1'b1;
            m_in++;
         end
         if (exp_v[16]) m_adv++;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
      #3;
      n_checks++;
      if (obs_v !== RESET_V) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs_v, RESET_V);
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || state !== 3'd0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_core: got ir=%b ov=%b st=%0d err=%b expected ir=1 ov=0 st=0 err=0",
                  in_ready, out_valid, state, err);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; in_valid = 1'b0;
      model_clear();
      $display("test_reset done");
   endtask

   task automatic test_continuous();
      int en_n = 0, first_ov = 0, last_adv = 0, done_cyc = 0, adv = 0;
      bit il;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         il = (m_in == NPIX - 1);
         drive(1'b1, il, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL cont_cycle%0d: got %h expected %h", c, obs_v, exp_v);
         end
         if (en) begin adv++; en_n++; end
         if (out_valid && first_ov == 0) first_ov = c;
         if (out_last) last_adv = adv;
         if (done) done_cyc = c;
         advance(1'b1, il);
      end
      in_valid = 1'b0;
      n_checks++;
      if (en_n != 16) begin n_fail++; $display("FAIL cont_en_count: got %0d expected 16", en_n); end
      n_checks++;
      if (first_ov != 5) begin n_fail++; $display("FAIL cont_first_ov: got %0d expected 5", first_ov); end
      n_checks++;
      if (last_adv != 16) begin n_fail++; $display("FAIL cont_last_adv: got %0d expected 16", last_adv); end
      n_checks++;
      if (done_cyc != 17) begin n_fail++; $display("FAIL cont_done_cyc: got %0d expected 17", done_cyc); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL cont_err: got %b expected 0", err); end
      $display("test_continuous done: en=%0d first_ov=%0d last_adv=%0d done=%0d", en_n, first_ov, last_adv, done_cyc);
   endtask

   task automatic test_backpressure();
      int bp = 0, done_cyc = 0, last_seen = 0;
      logic [AW-1:0] held = '0;
      bit il, ordy;
      for (int c = 1; c <= 50 && done_cyc == 0; c++) begin
         il   = (m_in == NPIX - 1);
         ordy = !(m_in >= 6 && bp < 3);
         drive(1'b1, il, ordy);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL bp_cycle%0d: got %h expected %h", c, obs_v, exp_v);
         end
         if (!ordy) begin
            if (bp == 0) held = lb_waddr;
            n_checks++;
            if (in_ready !== 1'b0 || en !== 1'b0 || lb_waddr !== held || lb_waddr !== AW'(2)) begin
               n_fail++;
               $display("FAIL bp_stall%0d: got ir=%b en=%b waddr=%0d expected ir=0 en=0 waddr=2",
                        bp, in_ready, en, lb_waddr);
            end
            bp++;
         end
         if (out_last) last_seen++;
         if (done) done_cyc = c;
         advance(1'b1, il);
      end
      in_valid = 1'b0;
      n_checks++;
      if (last_seen != 1 || done_cyc != 20 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_resume: got last=%0d done_cyc=%0d err=%b expected last=1 done_cyc=20 err=0",
                  last_seen, done_cyc, err);
      end
      $display("test_backpressure done: stalls=%0d done_cyc=%0d", bp, done_cyc);
   endtask

   task automatic test_early_last();
      int adv = 0, last_adv = 0, done_cyc = 0;
      bit il;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         il = (m_in == 4);
         drive(1'b1, il, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL early_cycle%0d: got %h expected %h", c, obs_v, exp_v);
         end
         if (en) adv++;
         if (out_last) last_adv = adv;
         if (done) done_cyc = c;
         advance(1'b1, il);
      end
      drive(1'b0, 1'b0, 1'b1);
      advance(1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (err !== 1'b1 || last_adv != 16) begin
         n_fail++; $display("FAIL early_err: got err=%b last_adv=%0d expected err=1 last_adv=16", err, last_adv);
      end
      advance(1'b0, 1'b0);
      $display("test_early_last done: err=%b last_adv=%0d", err, last_adv);
   endtask

   task automatic test_rotation_reset();
      int wsel_row[4] = '{-1, -1, -1, -1};
      int done_cyc = 0;
      bit il;
      do_reset();
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         il = (m_in == NPIX - 1);
         drive(1'b1, il, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL rot_cycle%0d: got %h expected %h", c, obs_v, exp_v);
         end
         if (en && lb_waddr == '0 && (c - 1) / W < 4) wsel_row[(c - 1) / W] = int'(lb_wsel);
         if (done) done_cyc = c;
         advance(1'b1, il);
      end
      for (int r = 0; r < 4; r++) begin
         n_checks++;
         if (wsel_row[r] != r) begin
            n_fail++; $display("FAIL rot_wsel_row%0d: got %0d expected %0d", r, wsel_row[r], r);
         end
      end
      for (int c = 1; c <= 20 && m_in < 7; c++) begin
         drive(1'b1, 1'b0, 1'b1);
         advance(1'b1, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_v !== RESET_V) begin
         n_fail++; $display("FAIL midrun_reset: got %h expected %h", obs_v, RESET_V);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear();
      done_cyc = 0;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         il = (m_in == NPIX - 1);
         drive(1'b1, il, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL restart_cycle%0d: got %h expected %h", c, obs_v, exp_v);
         end
         if (done) done_cyc = c;
         advance(1'b1, il);
      end
      in_valid = 1'b0;
      n_checks++;
      if (done_cyc != 17) begin n_fail++; $display("FAIL restart_done: got %0d expected 17", done_cyc); end
      $display("test_rotation_reset done: restart done_cyc=%0d", done_cyc);
   endtask

   task automatic test_random();
      int frames = 0, cyc = 0;
      bit iv, il, ordy;
      do_reset();
      while (frames < 5 && cyc < 800) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         il   = (m_in == NPIX - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
         drive(iv, il, ordy);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL rand_cycle%0d: got %h expected %h", cyc, obs_v, exp_v);
         end
         if (done) frames++;
         advance(iv, il);
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (frames != 5) begin n_fail++; $display("FAIL rand_frames: got %0d expected 5", frames); end
      $display("test_random done: frames=%0d cycles=%0d err=%b", frames, cyc, err);
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_backpressure();
      test_early_last();
      test_rotation_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_seq.md
FRAME_SEQ -- requirements
Module: frame_seq

Interface
REQ-001 Parameter IMG_W, default 512, pixels per row.
REQ-002 Parameter IMG_H, default 512, rows per frame.
REQ-003 Parameter PIPE_ROWS, default 2, row latency from the first input pixel to the first output pixel.
REQ-004 Parameter LB_NUM, default 4, number of rotating line-buffer RAMs.
REQ-005 Parameter ADDR_W, default 11, line-buffer address width.
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  upstream stream pixel valid.
REQ-009 in_last  in  1  upstream end-of-frame marker.
REQ-010 in_ready  out  1  upstream accept.
REQ-011 out_ready  in  1  downstream accept.
REQ-012 out_valid  out  1  downstream pixel valid.
REQ-013 out_last  out  1  final output pixel of the frame.
REQ-014 en  out  1  pipeline/line-buffer advance strobe (one pixel step).
REQ-015 lb_waddr  out  ADDR_W  line-buffer write/read column address.
REQ-016 lb_wsel  out  2  index of the line-buffer RAM written this row.
REQ-017 edg  out  1  current output pixel lies on the frame border.
REQ-018 state  out  3  current sequencer state.
REQ-019 done  out  1  one-cycle end-of-frame pulse.
REQ-020 err  out  1  sticky in_last framing error.

Function
REQ-021 States: IDLE=0, FILL=1, RUN=2, FLUSH=3, DONE=4; all other encodings go to IDLE.
REQ-022 IDLE: in_ready=1; first accepted pixel (in_valid & in_ready) -> FILL, or -> RUN if PIPE_ROWS=0.
REQ-023 FILL: in_ready=1, out_valid=0, en=in_valid; leaves for RUN after PIPE_ROWS*IMG_W accepted pixels.
REQ-024 RUN: out_valid=in_valid, in_ready=out_ready, en=in_valid & out_ready; leaves for FLUSH after the input pixel at (IMG_H-1, IMG_W-1) is accepted.
REQ-025 FLUSH: in_ready=0, out_valid=1, en=out_ready; leaves for DONE after PIPE_ROWS*IMG_W advances.
REQ-026 DONE: lasts exactly one cycle, done=1, en=0; then IDLE with all counters at 0.
REQ-027 Advance counter: col 0..IMG_W-1, row 0..IMG_H+PIPE_ROWS-1; increments only on en; col wraps to 0 and row increments at IMG_W-1.
REQ-028 lb_waddr equals the advance column, zero-extended to ADDR_W.
REQ-029 lb_wsel increments modulo LB_NUM on every row wrap.
REQ-030 Output row = advance row - PIPE_ROWS.
REQ-031 edg=1 when out_valid=1 and the output row is 0 or IMG_H-1, or the column is 0 or IMG_W-1.
REQ-032 out_last=1 when out_valid=1 at output row IMG_H-1, column IMG_W-1.
REQ-033 All outputs are combinational from registered state and counters; zero-cycle handshake latency.
REQ-034 err is set on either framing violation, and the frame continues on the counter, not on in_last:
- in_last accepted on any pixel other than the final input pixel;
- the final input pixel accepted without in_last.
REQ-035 err clears only on reset.
REQ-036 Backpressure: while en=0, counters, lb_wsel and state hold.

Reset
REQ-037 While rst_n=0, without waiting for a clock edge:
- state=IDLE; counters, lb_wsel, done and err = 0;
- in_ready=1; out_valid, out_last, en and edg = 0.
REQ-038 Reset asserted mid-frame abandons the frame; the next accepted pixel is treated as pixel (0,0).

Structure
REQ-039 The shared package holds the state encoding constants and the default IMG_W, IMG_H and ADDR_W values.
REQ-040 One sub-module, frame_cnt, holds the col/row counter with wrap, and the sequencer FSM instantiates it.

Verification
REQ-041 Benches run with IMG_W=4, IMG_H=3, PIPE_ROWS=1 and LB_NUM=4 unless stated otherwise.
REQ-042 Reset scenario: hold rst_n=0 -> in_ready=1, out_valid=0, state=0, err=0.
REQ-043 Continuous frame: in_valid=1, out_ready=1, in_last on pixel 12.
- en on 16 cycles; first out_valid at cycle 5;
- out_last on the 16th advance; done one cycle later; err=0.
REQ-044 Backpressure: out_ready=0 for 3 cycles during RUN -> in_ready=0, en=0, lb_waddr held; the frame resumes intact.
REQ-045 Early in_last on pixel 5 -> err=1 and stays 1; out_last still occurs on advance 16.
REQ-046 Rotation and reset: lb_wsel reads 0,1,2,3 over rows 0-3; rst_n=0 mid-RUN -> all outputs return to reset values immediately.
